mem0_stage: RTL

First memory stage: sits directly after `ex` and consumes `ex2mem0_bus`. It holds the pipeline register for that bus and decodes the load/store control. It generates aligned byte strobes and store data, and issues exactly one request per memory instruction on the data-SRAM address channel using a req/addr_ok handshake. It then passes load-formatting information, the ALU result and writeback info to `mem1` under a valid/allowin protocol.

---
 rtl/mem0_stage.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem0_stage.sv
// rtl/mem0_stage.sv - first memory stage: pipeline register, load/store decode, data-SRAM request
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ex2mem0_bus_i[107:0]          {mem_ctl[5:0], st_data, exe_result, rd_addr, rd_we, pc} from ex
//   ctl_ex_over_i                 ex has a finished instruction to hand over
//   ctl_mem0_allowin_o            mem0 accepts a new instruction this cycle
//   ctl_mem1_allowin_i            mem1 accepts
//   ctl_mem0_over_o               mem0 instruction complete
//   mem02mem1_bus_o[76:0]         {ale, is_load, ld_unsigned, size, addr_lo, exe_result, rd_addr, rd_we, pc}
//   data_req_o/wr/wstrb/addr/wdata  data-SRAM address channel, held until data_addr_ok_i
//   data_addr_ok_i                request accepted on this edge
//   ctl_mem0_dest_o               destination register for hazard detection, 0 when none
//   ctl_mem0_is_load_o            valid aligned load (load-use stall)
//   forward_mem0_data_o           exe_result for forwarding
module mem0_stage (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [107:0] ex2mem0_bus_i,
   input  logic         ctl_ex_over_i,
   output logic         ctl_mem0_allowin_o,
   input  logic         ctl_mem1_allowin_i,
   output logic         ctl_mem0_over_o,
   output logic [76:0]  mem02mem1_bus_o,
   output logic         data_req_o,
   output logic         data_wr_o,
   output logic [3:0]   data_wstrb_o,
   output logic [31:0]  data_addr_o,
   output logic [31:0]  data_wdata_o,
   input  logic         data_addr_ok_i,
   output logic [4:0]   ctl_mem0_dest_o,
   output logic         ctl_mem0_is_load_o,
   output logic [31:0]  forward_mem0_data_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,   // empty, non-memory op, or misaligned op
      S_REQ  = 2'd1,   // request outstanding on the address channel
      S_SENT = 2'd2    // request accepted, waiting for handoff to mem1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_valid;
   logic [107:0]  r_bus;

   logic          w_load;
   logic          w_store;
   logic          w_unsigned;
   logic [1:0]    w_size;
   logic [1:0]    w_size_norm;
   logic [31:0]   w_st_data;
   logic [31:0]   w_exe_result;
   logic [4:0]    w_rd_addr;
   logic          w_rd_we;
   logic [31:0]   w_pc;
   logic [1:0]    w_addr_lo;
   logic          w_ale;
   logic          w_rd_we_fwd;
   logic          w_req;
   logic          w_over;
   logic          w_allowin;
   logic          w_unused_ctl0;

   // Size 11 is treated as a word access.
   function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         2'b00:   f_misaligned = 1'b0;
         2'b01:   f_misaligned = lo[0];
         default: f_misaligned = (lo != 2'b00);
      endcase
   endfunction

   // Decode of the held instruction. Load wins when load and store are both set.
   assign w_load        = r_bus[107];
   assign w_store       = r_bus[106] & ~r_bus[107];
   assign w_unsigned    = r_bus[105];
   assign w_size        = r_bus[104:103];
   assign w_size_norm   = w_size[1] ? 2'b10 : w_size;
   assign w_unused_ctl0 = r_bus[102];
   assign w_st_data     = r_bus[101:70];
   assign w_exe_result  = r_bus[69:38];
   assign w_rd_addr     = r_bus[37:33];
   assign w_rd_we       = r_bus[32];
   assign w_pc          = r_bus[31:0];
   assign w_addr_lo     = w_exe_result[1:0];

   assign w_ale       = (w_load | w_store) & f_misaligned(w_size, w_addr_lo);
   // A misaligned load must not write back.
   assign w_rd_we_fwd = w_rd_we & ~(w_load & w_ale);

   always_comb begin
      w_req       = 1'b0;
      w_over      = 1'b0;
      w_allowin   = 1'b0;
      w_state_nxt = r_state;

      w_req     = (r_state == S_REQ);
      // Anything not waiting on a request is complete; a request completes on its accept edge.
      w_over    = r_valid & (~w_req | data_addr_ok_i);
      w_allowin = ~r_valid | (w_over & ctl_mem1_allowin_i);

      if (w_allowin) begin
         // Next state is decided from the incoming instruction so its request appears in the
         // first cycle it is held.
         if (ctl_ex_over_i & (ex2mem0_bus_i[107] | ex2mem0_bus_i[106])
             & ~f_misaligned(ex2mem0_bus_i[104:103], ex2mem0_bus_i[39:38]))
            w_state_nxt = S_REQ;
         else
            w_state_nxt = S_IDLE;
      end else if (w_req & data_addr_ok_i) begin
         w_state_nxt = S_SENT;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid <= 1'b0;
         r_bus   <= '0;
      end else if (w_allowin) begin
         r_valid <= ctl_ex_over_i;
         if (ctl_ex_over_i)
            r_bus <= ex2mem0_bus_i;
      end
   end

   always_comb begin
      data_wstrb_o = 4'b0000;
      data_wdata_o = 32'h0;
      if (w_store) begin
         case (w_size)
            2'b00: begin
               data_wstrb_o = 4'b0001 << w_addr_lo;
               data_wdata_o = {4{w_st_data[7:0]}};
            end
            2'b01: begin
               data_wstrb_o = w_addr_lo[1] ? 4'b1100 : 4'b0011;
               data_wdata_o = {2{w_st_data[15:0]}};
            end
            default: begin
               data_wstrb_o = 4'b1111;
               data_wdata_o = w_st_data;
            end
         endcase
      end
   end

   assign data_req_o          = w_req;
   assign data_wr_o           = w_store;
   assign data_addr_o         = w_exe_result;
   assign ctl_mem0_over_o     = w_over;
   assign ctl_mem0_allowin_o  = w_allowin;
   assign ctl_mem0_dest_o     = (r_valid & w_rd_we_fwd) ? w_rd_addr : 5'd0;
   assign ctl_mem0_is_load_o  = r_valid & w_load & ~w_ale;
   assign forward_mem0_data_o = w_exe_result;
   assign mem02mem1_bus_o     = {w_ale, w_load, w_unsigned, w_size_norm, w_addr_lo,
                                 w_exe_result, w_rd_addr, w_rd_we_fwd, w_pc};

endmodule
